// File: rtl/seven_segment_multi_digit_counter.sv
// Multi-digit BCD seconds counter: prescaler-driven up/down count with
// synchronous load, leading-zero blanking and time-multiplexed 7-segment drive.
module seven_segment_multi_digit_counter #(
  parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
  parameter int          NUM_DIGITS = 4,
  parameter logic [15:0] SCAN_DIV   = 16'd1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              compare_in,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    tick,
  output logic                    wrap
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [23:0]             prescaler;
  logic [23:0]             period;
  logic                    step_now;
  logic [4*NUM_DIGITS-1:0] stepped;
  logic                    step_wrap;
  logic [4*NUM_DIGITS-1:0] load_sat;

  logic [15:0]             scan_cnt;
  logic                    scan_term;
  logic [IDX_W-1:0]        digit_idx;
  logic [IDX_W-1:0]        idx_next;
  logic [NUM_DIGITS-1:0]   sel_next;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [3:0]              cur_digit;
  logic                    cur_blank;

  // Segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // Period select and step condition; >= makes a shrinking period step at once.
  always_comb begin
    period   = (compare_in != 8'd0) ? {6'b0, compare_in, 10'b0} : MAX_COUNT;
    step_now = enable && (prescaler >= (period - 24'd1));
  end

  // Ripple carry/borrow across digits; a carry out of the top digit is a wrap.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    stepped = count_bcd;
    carry   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = count_bcd[4*i +: 4];
      if (carry) begin
        if (up_down) begin
          if (d >= 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    step_wrap = carry;
  end

  // Clamp each load digit into 0..9 so the count never holds a non-BCD digit.
  always_comb begin
    load_sat = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_sat[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end
  end

  // Prescaler, count and step pulses; load wins over a coincident step.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      count_bcd <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      prescaler <= '0;
      count_bcd <= load_sat;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else if (step_now) begin
      prescaler <= '0;
      count_bcd <= stepped;
      tick      <= 1'b1;
      wrap      <= step_wrap;
    end else begin
      if (enable) prescaler <= prescaler + 24'd1;
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

  // Next scan index, its one-hot enable, and the digit/blank state it will show.
  always_comb begin
    logic upper_zero;
    scan_term = (scan_cnt >= (SCAN_DIV - 16'd1));
    if (scan_term) begin
      idx_next = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      idx_next = digit_idx;
    end
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero && (count_bcd[4*i +: 4] == 4'd0);
      blank_vec[i] = blank_lz && (i != 0) && upper_zero;
    end
    sel_next  = '0;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        sel_next[i] = 1'b1;
        cur_digit   = count_bcd[4*i +: 4];
        cur_blank   = blank_vec[i];
      end
    end
  end

  // Free-running scan; digit_sel and seg update together, seg refreshed every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      digit_sel <= NUM_DIGITS'(1);
      seg       <= 7'h3F;
    end else begin
      scan_cnt  <= scan_term ? 16'd0 : scan_cnt + 16'd1;
      digit_idx <= idx_next;
      digit_sel <= sel_next;
      seg       <= cur_blank ? 7'h00 : decode(cur_digit);
    end
  end

endmodule
